lsu_subword: RTL and testbench

//  Next-generation load/store unit: full RV32 LB/LH/LW/LBU/LHU/SB/SH/SW with byte-lane

---
 rtl/lsu_subword_if.sv | 48 ++++
 rtl/lsu_subword.sv | 180 ++++++++++++++++++
 tb/tb_lsu_subword.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_subword_if.sv
// Core-side request/handshake and data-memory port of the subword load/store unit.
// Latency: none (wires only).
// Backpressure: req_ready_o toward the core, mem_ready_i from memory.
//
// Ports (all from the LSU's point of view, slave modport):
//   core side   : req_valid_i, req_ready_o, is_load_i, is_store_i, funct3_i,
//                 base_addr_i, offset_i, store_data_i, load_data_o, done_o,
//                 err_o, err_code_o
//   memory side : mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_valid_o,
//                 mem_ready_i, mem_rdata_i
interface lsu_subword_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid_i;
  logic              req_ready_o;
  logic              is_load_i;
  logic              is_store_i;
  logic [2:0]        funct3_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W-1:0] offset_i;
  logic [31:0]       store_data_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_wstrb_o;
  logic              mem_valid_o;
  logic              mem_ready_i;
  logic [31:0]       mem_rdata_i;
  logic [31:0]       load_data_o;
  logic              done_o;
  logic              err_o;
  logic [1:0]        err_code_o;

  // The LSU itself.
  modport slave (
    input  req_valid_i, is_load_i, is_store_i, funct3_i, base_addr_i, offset_i,
           store_data_i, mem_ready_i, mem_rdata_i,
    output req_ready_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_valid_o,
           load_data_o, done_o, err_o, err_code_o
  );

  // Whoever drives the core request and models the memory.
  modport master (
    output req_valid_i, is_load_i, is_store_i, funct3_i, base_addr_i, offset_i,
           store_data_i, mem_ready_i, mem_rdata_i,
    input  req_ready_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_valid_o,
           load_data_o, done_o, err_o, err_code_o
  );
endinterface

// File: rtl/lsu_subword.sv
// RV32 subword load/store unit: LB/LH/LW/LBU/LHU/SB/SH/SW with strobes, extension, alignment checks.
// Latency: done_o 2 cycles after accept when memory is ready at once; err_o 1 cycle after accept.
// Backpressure: req_ready_o only in IDLE; waits on mem_ready_i, aborting after TIMEOUT cycles (0 = never).
//
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset; aborts any operation in flight
//   bus    lsu_subword_if.slave (core request, result/status, memory port)
module lsu_subword #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  lsu_subword_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_load;
  logic [2:0]        op_funct3;
  logic [1:0]        op_lane;

  // Request decode, only meaningful in the accepting cycle.
  logic [ADDR_W-1:0] ea;
  logic              illegal;
  logic              misaligned;
  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;

  assign ea = bus.base_addr_i + bus.offset_i;
  assign bus.req_ready_o = (state == IDLE) && !rst_i;

  always_comb begin
    illegal = 1'b0;
    if (bus.is_load_i == bus.is_store_i) begin
      illegal = 1'b1;
    end else if (bus.is_load_i) begin
      illegal = !(bus.funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else begin
      illegal = !(bus.funct3_i inside {3'b000, 3'b001, 3'b010});
    end
  end

  // funct3[1:0] is the access size for both signed and unsigned variants.
  always_comb begin
    misaligned = 1'b0;
    case (bus.funct3_i[1:0])
      2'b01:   misaligned = ea[0];
      2'b10:   misaligned = |ea[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Lane replication means memory can pick the bytes purely from the strobes.
  always_comb begin
    st_wdata = 32'h0;
    st_wstrb = 4'b0000;
    if (bus.is_store_i) begin
      case (bus.funct3_i[1:0])
        2'b00: begin
          st_wdata = {4{bus.store_data_i[7:0]}};
          st_wstrb = 4'b0001 << ea[1:0];
        end
        2'b01: begin
          st_wdata = {2{bus.store_data_i[15:0]}};
          st_wstrb = 4'b0011 << ea[1:0];
        end
        default: begin
          st_wdata = bus.store_data_i;
          st_wstrb = 4'b1111;
        end
      endcase
    end
  end

  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      op_load         <= 1'b0;
      op_funct3       <= 3'b000;
      op_lane         <= 2'b00;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= 32'h0;
      bus.mem_wstrb_o <= 4'b0000;
      bus.mem_valid_o <= 1'b0;
      bus.load_data_o <= 32'h0;
      bus.done_o      <= 1'b0;
      bus.err_o       <= 1'b0;
      bus.err_code_o  <= 2'b00;
    end else begin
      bus.done_o <= 1'b0;
      bus.err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            cnt       <= '0;
            op_load   <= bus.is_load_i;
            op_funct3 <= bus.funct3_i;
            op_lane   <= ea[1:0];
            if (illegal) begin
              state          <= ERR;
              bus.err_o      <= 1'b1;
              bus.err_code_o <= ERR_ILLEGAL;
            end else if (misaligned) begin
              state          <= ERR;
              bus.err_o      <= 1'b1;
              bus.err_code_o <= ERR_MISALIGN;
            end else begin
              state           <= ACCESS;
              bus.mem_valid_o <= 1'b1;
              bus.mem_addr_o  <= {ea[ADDR_W-1:2], 2'b00};
              bus.mem_wdata_o <= st_wdata;
              bus.mem_wstrb_o <= st_wstrb;
            end
          end
        end
        ACCESS: begin
          // Ready is checked before the timeout so a last-cycle response still completes.
          if (bus.mem_ready_i) begin
            state           <= DONE;
            bus.done_o      <= 1'b1;
            bus.mem_valid_o <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= 32'h0;
            bus.mem_wstrb_o <= 4'b0000;
            if (op_load) begin
              bus.load_data_o <= load_extend(op_funct3, op_lane, bus.mem_rdata_i);
            end
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            state           <= ERR;
            bus.err_o       <= 1'b1;
            bus.err_code_o  <= ERR_TIMEOUT;
            bus.mem_valid_o <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= 32'h0;
            bus.mem_wstrb_o <= 4'b0000;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
// Directed self-checking bench for lsu_subword (built with TIMEOUT=4).
// Latency: stimulus driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: memory ready is driven per scenario to exercise waits and timeouts.
module tb_lsu_subword;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] exp_ld = 32'h0;

  always #5 clk_i = ~clk_i;

  lsu_subword_if #(.ADDR_W(32)) bus ();

  lsu_subword #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one request for a single cycle; returns just after the accept edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] sd);
    bus.req_valid_i  = 1'b1;
    bus.is_load_i    = ld;
    bus.is_store_i   = st;
    bus.funct3_i     = f3;
    bus.base_addr_i  = base;
    bus.offset_i     = off;
    bus.store_data_i = sd;
    tick();
    bus.req_valid_i  = 1'b0;
    bus.base_addr_i  = 32'hFFFF_FFFF;
    bus.store_data_i = 32'h5555_5555;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    vectors++;
    if ({bus.req_ready_o, bus.mem_valid_o, bus.done_o, bus.err_o, bus.err_code_o} !== 6'b0 ||
        bus.mem_addr_o !== 32'h0 || bus.mem_wdata_o !== 32'h0 || bus.mem_wstrb_o !== 4'h0 ||
        bus.load_data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b valid=%b done=%b err=%b code=%b addr=%h wdata=%h wstrb=%b ld=%h, all required 0",
               bus.req_ready_o, bus.mem_valid_o, bus.done_o, bus.err_o, bus.err_code_o,
               bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o, bus.load_data_o);
    end
    rst_i = 1'b0;
    #1;
    vectors++;
    if (bus.req_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b want 1", bus.req_ready_o);
    end
    tick();
  endtask

  task automatic test_lw();
    // Ready held high before the accept must be ignored while IDLE.
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'hDEAD_BEEF;
    issue(1'b1, 1'b0, 3'b010, 32'h1000, 32'h4, 32'h0);
    vectors++;
    if (bus.mem_valid_o !== 1'b1 || bus.mem_addr_o !== 32'h1004 || bus.mem_wstrb_o !== 4'b0000 ||
        bus.done_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_access: valid=%b addr=%h wstrb=%b done=%b ready=%b want 1 00001004 0000 0 0",
               bus.mem_valid_o, bus.mem_addr_o, bus.mem_wstrb_o, bus.done_o, bus.req_ready_o);
    end
    tick();
    exp_ld = 32'hDEAD_BEEF;
    vectors++;
    if (bus.done_o !== 1'b1 || bus.mem_valid_o !== 1'b0 || bus.load_data_o !== exp_ld) begin
      miscompares++;
      $display("FAIL lw_done: done=%b valid=%b ld=%h want 1 0 %h",
               bus.done_o, bus.mem_valid_o, bus.load_data_o, exp_ld);
    end
    tick();
    vectors++;
    if (bus.done_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL lw_pulse_end: done=%b ready=%b want 0 1", bus.done_o, bus.req_ready_o);
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3 [4];
    logic [31:0] base [4];
    logic [31:0] off [4];
    logic [31:0] want [4];
    f3[0] = 3'b000; base[0] = 32'h1000; off[0] = 32'h3;         want[0] = 32'hFFFF_FF80;
    f3[1] = 3'b100; base[1] = 32'h1000; off[1] = 32'h3;         want[1] = 32'h0000_0080;
    f3[2] = 3'b001; base[2] = 32'h1000; off[2] = 32'h2;         want[2] = 32'hFFFF_80FF;
    f3[3] = 3'b101; base[3] = 32'h100A; off[3] = 32'hFFFF_FFFC; want[3] = 32'h0000_80FF;
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h80FF_0000;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, f3[i], base[i], off[i], 32'h0);
      vectors++;
      if (bus.mem_addr_o !== ((base[i] + off[i]) & 32'hFFFF_FFFC)) begin
        miscompares++;
        $display("FAIL ldext_addr[%0d]: got %h want %h", i, bus.mem_addr_o,
                 (base[i] + off[i]) & 32'hFFFF_FFFC);
      end
      tick();
      exp_ld = want[i];
      vectors++;
      if (bus.done_o !== 1'b1 || bus.load_data_o !== exp_ld) begin
        miscompares++;
        $display("FAIL ldext_data[%0d]: done=%b ld=%h want 1 %h", i, bus.done_o, bus.load_data_o, exp_ld);
      end
      tick();
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3 [3];
    logic [31:0] off [3];
    logic [31:0] sd [3];
    logic [31:0] waddr [3];
    logic [31:0] wdat [3];
    logic [3:0]  wstb [3];
    f3[0] = 3'b001; off[0] = 32'h2; sd[0] = 32'h1234_ABCD; waddr[0] = 32'h2000; wdat[0] = 32'hABCD_ABCD; wstb[0] = 4'b1100;
    f3[1] = 3'b000; off[1] = 32'h5; sd[1] = 32'h1234_56EF; waddr[1] = 32'h2004; wdat[1] = 32'hEFEF_EFEF; wstb[1] = 4'b0010;
    f3[2] = 3'b010; off[2] = 32'h8; sd[2] = 32'hCAFE_F00D; waddr[2] = 32'h2008; wdat[2] = 32'hCAFE_F00D; wstb[2] = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready_i = 1'b0;
      bus.mem_rdata_i = 32'h0BAD_0BAD;
      issue(1'b0, 1'b1, f3[i], 32'h2000, off[i], sd[i]);
      tick();
      // Second wait cycle: request must be unchanged while memory stalls.
      vectors++;
      if (bus.mem_valid_o !== 1'b1 || bus.mem_addr_o !== waddr[i] ||
          bus.mem_wdata_o !== wdat[i] || bus.mem_wstrb_o !== wstb[i]) begin
        miscompares++;
        $display("FAIL store_bus[%0d]: valid=%b addr=%h wdata=%h wstrb=%b want 1 %h %h %b",
                 i, bus.mem_valid_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o,
                 waddr[i], wdat[i], wstb[i]);
      end
      bus.mem_ready_i = 1'b1;
      tick();
      bus.mem_ready_i = 1'b0;
      vectors++;
      if (bus.done_o !== 1'b1 || bus.load_data_o !== exp_ld || bus.mem_wstrb_o !== 4'b0000) begin
        miscompares++;
        $display("FAIL store_done[%0d]: done=%b ld=%h wstrb=%b want 1 %h 0000",
                 i, bus.done_o, bus.load_data_o, bus.mem_wstrb_o, exp_ld);
      end
      tick();
    end
  endtask

  task automatic test_errors();
    logic        ld [5];
    logic        st [5];
    logic [2:0]  f3 [5];
    logic [31:0] off [5];
    logic [1:0]  code [5];
    ld[0] = 1; st[0] = 0; f3[0] = 3'b010; off[0] = 32'h2; code[0] = 2'b01;
    ld[1] = 1; st[1] = 0; f3[1] = 3'b011; off[1] = 32'h0; code[1] = 2'b11;
    ld[2] = 1; st[2] = 1; f3[2] = 3'b000; off[2] = 32'h0; code[2] = 2'b11;
    ld[3] = 0; st[3] = 1; f3[3] = 3'b100; off[3] = 32'h0; code[3] = 2'b11;
    ld[4] = 0; st[4] = 1; f3[4] = 3'b001; off[4] = 32'h1; code[4] = 2'b01;
    bus.mem_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(ld[i], st[i], f3[i], 32'h1000, off[i], 32'h0);
      vectors++;
      if (bus.err_o !== 1'b1 || bus.err_code_o !== code[i] || bus.mem_valid_o !== 1'b0 ||
          bus.done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL err_pulse[%0d]: err=%b code=%b valid=%b done=%b want 1 %b 0 0",
                 i, bus.err_o, bus.err_code_o, bus.mem_valid_o, bus.done_o, code[i]);
      end
      tick();
      vectors++;
      if (bus.err_o !== 1'b0 || bus.err_code_o !== code[i] || bus.req_ready_o !== 1'b1 ||
          bus.mem_valid_o !== 1'b0 || bus.load_data_o !== exp_ld) begin
        miscompares++;
        $display("FAIL err_after[%0d]: err=%b code=%b ready=%b valid=%b ld=%h want 0 %b 1 0 %h",
                 i, bus.err_o, bus.err_code_o, bus.req_ready_o, bus.mem_valid_o,
                 bus.load_data_o, code[i], exp_ld);
      end
    end
  endtask

  task automatic test_timeout();
    int valid_cycles;
    int done_seen;
    int err_seen;
    bus.mem_ready_i = 1'b0;
    valid_cycles = 0;
    done_seen = 0;
    err_seen = 0;
    issue(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 32'h0);
    for (int c = 0; c < 10 && err_seen == 0; c++) begin
      if (bus.mem_valid_o === 1'b1) valid_cycles++;
      if (bus.done_o === 1'b1) done_seen++;
      tick();
      if (bus.err_o === 1'b1) err_seen = 1;
    end
    vectors++;
    if (valid_cycles != 4 || err_seen != 1 || done_seen != 0 || bus.err_code_o !== 2'b10) begin
      miscompares++;
      $display("FAIL timeout: valid_cycles=%0d err=%0d done=%0d code=%b want 4 1 0 10",
               valid_cycles, err_seen, done_seen, bus.err_code_o);
    end
    tick();
    // Ready arriving in the last allowed cycle must complete, not time out.
    bus.mem_rdata_i = 32'h0102_0304;
    issue(1'b1, 1'b0, 3'b010, 32'h3000, 32'h4, 32'h0);
    tick();
    tick();
    tick();
    bus.mem_ready_i = 1'b1;
    tick();
    bus.mem_ready_i = 1'b0;
    exp_ld = 32'h0102_0304;
    vectors++;
    if (bus.done_o !== 1'b1 || bus.err_o !== 1'b0 || bus.load_data_o !== exp_ld) begin
      miscompares++;
      $display("FAIL timeout_last_ready: done=%b err=%b ld=%h want 1 0 %h",
               bus.done_o, bus.err_o, bus.load_data_o, exp_ld);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = 32'h7777_7777;
    issue(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'h0);
    tick();
    rst_i = 1'b1;
    bus.mem_ready_i = 1'b1;
    tick();
    vectors++;
    if (bus.mem_valid_o !== 1'b0 || bus.done_o !== 1'b0 || bus.err_o !== 1'b0 ||
        bus.load_data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b done=%b err=%b ld=%h want 0 0 0 00000000",
               bus.mem_valid_o, bus.done_o, bus.err_o, bus.load_data_o);
    end
    rst_i = 1'b0;
    tick();
    vectors++;
    if (bus.done_o !== 1'b0 || bus.err_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_after: done=%b err=%b ready=%b want 0 0 1",
               bus.done_o, bus.err_o, bus.req_ready_o);
    end
    bus.mem_rdata_i = 32'h1357_9BDF;
    issue(1'b1, 1'b0, 3'b010, 32'h4000, 32'h8, 32'h0);
    tick();
    exp_ld = 32'h1357_9BDF;
    vectors++;
    if (bus.done_o !== 1'b1 || bus.load_data_o !== exp_ld) begin
      miscompares++;
      $display("FAIL reset_mid_recover: done=%b ld=%h want 1 %h", bus.done_o, bus.load_data_o, exp_ld);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'hA5A5_0001;
    issue(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 32'h0);
    tick();
    vectors++;
    if (bus.done_o !== 1'b1 || bus.req_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first: done=%b ready=%b want 1 0", bus.done_o, bus.req_ready_o);
    end
    tick();
    bus.mem_rdata_i = 32'hA5A5_0002;
    issue(1'b1, 1'b0, 3'b010, 32'h5000, 32'h4, 32'h0);
    vectors++;
    if (bus.mem_valid_o !== 1'b1 || bus.mem_addr_o !== 32'h5004) begin
      miscompares++;
      $display("FAIL b2b_accept: valid=%b addr=%h want 1 00005004", bus.mem_valid_o, bus.mem_addr_o);
    end
    tick();
    exp_ld = 32'hA5A5_0002;
    vectors++;
    if (bus.done_o !== 1'b1 || bus.load_data_o !== exp_ld) begin
      miscompares++;
      $display("FAIL b2b_second: done=%b ld=%h want 1 %h", bus.done_o, bus.load_data_o, exp_ld);
    end
    tick();
  endtask

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.is_load_i    = 1'b0;
    bus.is_store_i   = 1'b0;
    bus.funct3_i     = 3'b000;
    bus.base_addr_i  = 32'h0;
    bus.offset_i     = 32'h0;
    bus.store_data_i = 32'h0;
    bus.mem_ready_i  = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    #1;
    test_reset();
    test_lw();
    test_load_extend();
    test_store();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
